// File: rtl/cheshire_eoc_mon.sv
// End-of-computation monitor: snoops register writes to per-channel EOC words and reports
// completion, pass/fail from the latched exit codes, or a global timeout.
module cheshire_eoc_mon #(
    parameter int unsigned NumChannels = 4,
    parameter logic [63:0] BaseAddr    = 64'h0300_0004,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [CntWidth-1:0]       timeout_i,
    input  logic                      wr_valid_i,
    input  logic [63:0]               wr_addr_i,
    input  logic [31:0]               wr_data_i,
    input  logic [3:0]                wr_strb_i,
    output logic [NumChannels-1:0]    ch_done_o,
    output logic [NumChannels*31-1:0] exit_code_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE,
        TIMEOUT
    } state_e;

    state_e                    state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic [NumChannels-1:0]    ch_done_q, ch_done_d;
    logic [NumChannels*31-1:0] exit_code_q, exit_code_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
    logic                      timeout_q, timeout_d;
    logic                      busy_q, busy_d;
    logic [NumChannels-1:0]    hit;
    logic                      expire;

    // A write retires channel k only while armed, with full strobes, the EOC bit set,
    // and only the first time (first EOC wins).
    always_comb begin
        hit = '0;
        for (int k = 0; k < NumChannels; k++) begin
            if (state_q == ARMED && wr_valid_i && wr_strb_i == 4'hF && wr_data_i[0] &&
                wr_addr_i == BaseAddr + 64'(4 * k) && !ch_done_q[k]) begin
                hit[k] = 1'b1;
            end
        end
    end

    assign expire = (timeout_i != '0) && (cnt_q == timeout_i - CntWidth'(1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_done_d   = ch_done_q;
        exit_code_d = exit_code_q;

        if (start_i) begin
            state_d     = ARMED;
            cnt_d       = '0;
            ch_done_d   = '0;
            exit_code_d = '0;
        end else if (state_q == ARMED) begin
            cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);
            ch_done_d = ch_done_q | hit;
            for (int k = 0; k < NumChannels; k++) begin
                if (hit[k]) begin
                    exit_code_d[31*k +: 31] = wr_data_i[31:1];
                end
            end
            // Completion beats a same-cycle expiry.
            if (&ch_done_d) begin
                state_d = DONE;
            end else if (expire) begin
                state_d = TIMEOUT;
            end
        end

        // NOTE: status flags are decoded from the next state so the registered outputs
        // change on the same edge as the state itself.
        busy_d    = (state_d == ARMED);
        done_d    = (state_d == DONE);
        timeout_d = (state_d == TIMEOUT);
        pass_d    = done_d && (exit_code_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_done_q   <= '0;
            exit_code_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_done_q   <= ch_done_d;
            exit_code_q <= exit_code_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign ch_done_o   = ch_done_q;
    assign exit_code_o = exit_code_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;

endmodule
